sparc_window_decoder: RTL and testbench

- Parametrised, windowed register-file address decoder for the SPARC register file.
- Holds the current window pointer (CWP) and the window invalid mask (WIM).
- Maps the 5-bit logical register numbers to physical register indices, with overlapping in/out windows.
- Produces a registered one-hot write enable for the register-file bank and raises window overflow/underflow trap pulses on SAVE/RESTORE.

---
 rtl/sparc_rf_pkg.sv | 12 +
 rtl/sparc_window_map.sv | 33 +++
 rtl/sparc_window_decoder.sv | 92 +++++++++
 tb/tb_sparc_window_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sparc_rf_pkg.sv
// Shared constants and sizing helper for the windowed SPARC register file.
package sparc_rf_pkg;

    localparam int GLOBALS    = 8;
    localparam int WIN_REGS   = 16;
    localparam int LOG_ADDR_W = 5;

    function automatic int nphys(input int nwin);
        return GLOBALS + WIN_REGS * nwin;
    endfunction

endpackage

// File: rtl/sparc_window_map.sv
// Combinational logical-register to physical-index map for one window pointer.
module sparc_window_map
    import sparc_rf_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = $clog2(NWINDOWS),
    parameter int PHYS_W   = $clog2(nphys(NWINDOWS))
) (
    input  logic [LOG_ADDR_W-1:0] addr,
    input  logic [CWP_W-1:0]      cwp,
    output logic [PHYS_W-1:0]     phys
);

    int w;
    int wn;
    int off;
    int idx;

    always_comb begin
        w   = int'(cwp);
        // ins alias the outs of the next window; wrap by compare so odd window counts work
        wn  = (w == NWINDOWS - 1) ? 0 : w + 1;
        off = int'(addr[2:0]);
        unique case (addr[4:3])
            2'd0:    idx = off;
            2'd1:    idx = GLOBALS + WIN_REGS * w + off;
            2'd2:    idx = 2 * GLOBALS + WIN_REGS * w + off;
            default: idx = GLOBALS + WIN_REGS * wn + off;
        endcase
        phys = PHYS_W'(idx);
    end

endmodule

// File: rtl/sparc_window_decoder.sv
// Windowed register-file address decoder: CWP/WIM state, read/write decode
// and SAVE/RESTORE overflow/underflow trap pulses.
module sparc_window_decoder
    import sparc_rf_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int NPHYS    = nphys(NWINDOWS),
    parameter int CWP_W    = $clog2(NWINDOWS),
    parameter int PHYS_W   = $clog2(NPHYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [LOG_ADDR_W-1:0] wr_addr,
    input  logic [LOG_ADDR_W-1:0] rs1_addr,
    input  logic [LOG_ADDR_W-1:0] rs2_addr,
    output logic [PHYS_W-1:0]     rs1_phys,
    output logic [PHYS_W-1:0]     rs2_phys,
    output logic [NPHYS-1:0]      we_onehot,
    input  logic                  save,
    input  logic                  restore,
    input  logic                  cwp_we,
    input  logic [CWP_W-1:0]      cwp_wdata,
    input  logic                  wim_we,
    input  logic [NWINDOWS-1:0]   wim_wdata,
    output logic [CWP_W-1:0]      cwp,
    output logic [NWINDOWS-1:0]   wim,
    output logic                  overflow_trap,
    output logic                  underflow_trap
);

    logic [PHYS_W-1:0] wr_phys;
    logic [CWP_W-1:0]  save_cwp;
    logic [CWP_W-1:0]  rest_cwp;
    logic [CWP_W-1:0]  wdata_mod;

    sparc_window_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_rs1 (
        .addr (rs1_addr),
        .cwp  (cwp),
        .phys (rs1_phys)
    );

    sparc_window_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_rs2 (
        .addr (rs2_addr),
        .cwp  (cwp),
        .phys (rs2_phys)
    );

    sparc_window_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_wr (
        .addr (wr_addr),
        .cwp  (cwp),
        .phys (wr_phys)
    );

    always_comb begin
        save_cwp = (cwp == '0) ? CWP_W'(NWINDOWS - 1) : cwp - CWP_W'(1);
        rest_cwp = (int'(cwp) == NWINDOWS - 1) ? '0 : cwp + CWP_W'(1);
        // cwp_wdata is below 2*NWINDOWS, so a single conditional subtract is a full modulo
        wdata_mod = (int'(cwp_wdata) >= NWINDOWS) ? CWP_W'(int'(cwp_wdata) - NWINDOWS)
                                                  : cwp_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cwp            <= '0;
            wim            <= '0;
            we_onehot      <= '0;
            overflow_trap  <= 1'b0;
            underflow_trap <= 1'b0;
        end else begin
            overflow_trap  <= 1'b0;
            underflow_trap <= 1'b0;
            we_onehot      <= (wr_en && wr_addr != '0) ? (NPHYS'(1) << wr_phys) : '0;
            if (wim_we)
                wim <= wim_wdata;
            if (cwp_we) begin
                cwp <= wdata_mod;
            end else if (save && !restore) begin
                if (wim[save_cwp])
                    overflow_trap <= 1'b1;
                else
                    cwp <= save_cwp;
            end else if (restore && !save) begin
                if (wim[rest_cwp])
                    underflow_trap <= 1'b1;
                else
                    cwp <= rest_cwp;
            end
        end
    end

endmodule

// File: tb/tb_sparc_window_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_sparc_window_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // NWINDOWS=8 instance
    logic         wr_en, save, restore, cwp_we, wim_we;
    logic [4:0]   wr_addr, rs1_addr, rs2_addr;
    logic [2:0]   cwp_wdata;
    logic [7:0]   wim_wdata;
    logic [7:0]   rs1_phys, rs2_phys;
    logic [135:0] we_onehot;
    logic [2:0]   cwp;
    logic [7:0]   wim;
    logic         overflow_trap, underflow_trap;

    // NWINDOWS=5 instance
    logic         f_wr_en, f_save, f_restore, f_cwp_we, f_wim_we;
    logic [4:0]   f_wr_addr, f_rs1_addr, f_rs2_addr;
    logic [2:0]   f_cwp_wdata;
    logic [4:0]   f_wim_wdata;
    logic [6:0]   f_rs1_phys, f_rs2_phys;
    logic [87:0]  f_we_onehot;
    logic [2:0]   f_cwp;
    logic [4:0]   f_wim;
    logic         f_overflow_trap, f_underflow_trap;

    sparc_window_decoder #(.NWINDOWS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_phys(rs1_phys), .rs2_phys(rs2_phys),
        .we_onehot(we_onehot), .save(save), .restore(restore), .cwp_we(cwp_we),
        .cwp_wdata(cwp_wdata), .wim_we(wim_we), .wim_wdata(wim_wdata), .cwp(cwp), .wim(wim),
        .overflow_trap(overflow_trap), .underflow_trap(underflow_trap)
    );

    sparc_window_decoder #(.NWINDOWS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_addr(f_wr_addr),
        .rs1_addr(f_rs1_addr), .rs2_addr(f_rs2_addr), .rs1_phys(f_rs1_phys), .rs2_phys(f_rs2_phys),
        .we_onehot(f_we_onehot), .save(f_save), .restore(f_restore), .cwp_we(f_cwp_we),
        .cwp_wdata(f_cwp_wdata), .wim_we(f_wim_we), .wim_wdata(f_wim_wdata), .cwp(f_cwp), .wim(f_wim),
        .overflow_trap(f_overflow_trap), .underflow_trap(f_underflow_trap)
    );

    typedef struct {
        bit           sel;
        string        nm;
        logic [4:0]   cwp;
        logic [7:0]   wim;
        logic         ovf;
        logic         unf;
        logic [135:0] we;
        logic [9:0]   rs1;
        logic [9:0]   rs2;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input string fld, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic push(input bit sel, input string nm, input int ecwp, input int ewim,
                        input bit eovf, input bit eunf, input int ewe, input int er1, input int er2);
        exp_t e;
        e.sel = sel;
        e.nm  = nm;
        e.cwp = 5'(ecwp);
        e.wim = 8'(ewim);
        e.ovf = eovf;
        e.unf = eunf;
        e.we  = (ewe < 0) ? '0 : (136'(1) << ewe);
        e.rs1 = 10'(er1);
        e.rs2 = 10'(er2);
        q.push_back(e);
    endtask

    task automatic idle_all();
        wr_en = 0; wr_addr = 0; rs1_addr = 0; rs2_addr = 0; save = 0; restore = 0;
        cwp_we = 0; cwp_wdata = 0; wim_we = 0; wim_wdata = 0;
        f_wr_en = 0; f_wr_addr = 0; f_rs1_addr = 0; f_rs2_addr = 0; f_save = 0; f_restore = 0;
        f_cwp_we = 0; f_cwp_wdata = 0; f_wim_we = 0; f_wim_wdata = 0;
    endtask

    // Drive one cycle of stimulus to the selected instance; expectations describe the state after the next edge.
    task automatic step(input bit sel, input string nm, input bit wen, input int wa, input int r1, input int r2,
                        input bit sv, input bit rs, input bit cw, input int cwd, input bit ww, input int wwd,
                        input int ecwp, input int ewim, input bit eovf, input bit eunf,
                        input int ewe, input int er1, input int er2);
        @(negedge clk);
        idle_all();
        if (sel == 1'b0) begin
            wr_en = wen; wr_addr = 5'(wa); rs1_addr = 5'(r1); rs2_addr = 5'(r2);
            save = sv; restore = rs; cwp_we = cw; cwp_wdata = 3'(cwd); wim_we = ww; wim_wdata = 8'(wwd);
        end else begin
            f_wr_en = wen; f_wr_addr = 5'(wa); f_rs1_addr = 5'(r1); f_rs2_addr = 5'(r2);
            f_save = sv; f_restore = rs; f_cwp_we = cw; f_cwp_wdata = 3'(cwd); f_wim_we = ww; f_wim_wdata = 5'(wwd);
        end
        push(sel, nm, ecwp, ewim, eovf, eunf, ewe, er1, er2);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                if (e.sel == 1'b0) begin
                    chk(e.nm, "cwp", 136'(cwp), 136'(e.cwp));
                    chk(e.nm, "wim", 136'(wim), 136'(e.wim));
                    chk(e.nm, "ovf", 136'(overflow_trap), 136'(e.ovf));
                    chk(e.nm, "unf", 136'(underflow_trap), 136'(e.unf));
                    chk(e.nm, "we", we_onehot, e.we);
                    chk(e.nm, "rs1", 136'(rs1_phys), 136'(e.rs1));
                    chk(e.nm, "rs2", 136'(rs2_phys), 136'(e.rs2));
                end else begin
                    chk(e.nm, "cwp", 136'(f_cwp), 136'(e.cwp));
                    chk(e.nm, "wim", 136'(f_wim), 136'(e.wim));
                    chk(e.nm, "ovf", 136'(f_overflow_trap), 136'(e.ovf));
                    chk(e.nm, "unf", 136'(f_underflow_trap), 136'(e.unf));
                    chk(e.nm, "we", 136'(f_we_onehot), e.we);
                    chk(e.nm, "rs1", 136'(f_rs1_phys), 136'(e.rs1));
                    chk(e.nm, "rs2", 136'(f_rs2_phys), 136'(e.rs2));
                end
            end
        end
    end

    initial begin
        idle_all();
        //   sel name            wen wa  r1  r2 sv rs cw cwd ww wwd    ecwp ewim eovf eunf ewe  er1  er2
        step(0, "in_reset",      1,  1,  0,  0, 0, 0, 0, 0,  0, 0,     0,   0,    0,   0,   -1,  0,   0);
        @(posedge clk); #3; rst_n = 1'b1;

        step(0, "idle",          0,  0,  0,  0, 0, 0, 0, 0,  0, 0,     0,   0,    0,   0,   -1,  0,   0);
        step(0, "wr_r1",         1,  1,  8, 16, 0, 0, 0, 0,  0, 0,     0,   0,    0,   0,   1,   8,   16);
        step(0, "wr_r0",         1,  0, 24,  0, 0, 0, 0, 0,  0, 0,     0,   0,    0,   0,   -1,  24,  0);
        step(0, "wr_r9",         1,  9, 31, 17, 0, 0, 0, 0,  0, 0,     0,   0,    0,   0,   9,   31,  17);
        step(0, "save_c0",       1, 24, 24, 15, 1, 0, 0, 0,  0, 0,     7,   0,    0,   0,   24,  8,   127);
        step(0, "wr_c7",         1, 16,  8, 31, 0, 0, 0, 0,  0, 0,     7,   0,    0,   0,   128, 120, 15);
        step(0, "restore_c7",    1, 31, 15,  0, 0, 1, 0, 0,  0, 0,     0,   0,    0,   0,   15,  15,  0);
        for (int i = 0; i < 8; i++)
            step(0, "save_loop", 0,  0,  0,  0, 1, 0, 0, 0,  0, 0,     7-i, 0,    0,   0,   -1,  0,   0);
        step(0, "wim_80",        0,  0,  0,  0, 0, 0, 0, 0,  1, 'h80,  0,   'h80, 0,   0,   -1,  0,   0);
        step(0, "ovf",           1,  1,  0,  0, 1, 0, 0, 0,  0, 0,     0,   'h80, 1,   0,   1,   0,   0);
        step(0, "ovf_end",       0,  0,  0,  0, 0, 0, 0, 0,  0, 0,     0,   'h80, 0,   0,   -1,  0,   0);
        step(0, "wim_02",        0,  0,  0,  0, 0, 0, 0, 0,  1, 'h02,  0,   'h02, 0,   0,   -1,  0,   0);
        step(0, "unf",           0,  0,  0,  0, 0, 1, 0, 0,  0, 0,     0,   'h02, 0,   1,   -1,  0,   0);
        step(0, "unf_end",       0,  0,  0,  0, 0, 0, 0, 0,  0, 0,     0,   'h02, 0,   0,   -1,  0,   0);
        step(0, "unf_b2b_a",     0,  0,  0,  0, 0, 1, 0, 0,  0, 0,     0,   'h02, 0,   1,   -1,  0,   0);
        step(0, "unf_b2b_b",     0,  0,  0,  0, 0, 1, 0, 0,  0, 0,     0,   'h02, 0,   1,   -1,  0,   0);
        step(0, "unf_b2b_end",   0,  0,  0,  0, 0, 0, 0, 0,  0, 0,     0,   'h02, 0,   0,   -1,  0,   0);
        step(0, "wim_00",        0,  0,  0,  0, 0, 0, 0, 0,  1, 0,     0,   0,    0,   0,   -1,  0,   0);
        step(0, "save_restore",  0,  0,  0,  0, 1, 1, 0, 0,  0, 0,     0,   0,    0,   0,   -1,  0,   0);
        step(0, "cwpwe_save",    0,  0,  0,  0, 1, 0, 1, 5,  0, 0,     5,   0,    0,   0,   -1,  0,   0);
        step(0, "cwpwe_7",       0,  0,  0,  0, 0, 0, 1, 7,  0, 0,     7,   0,    0,   0,   -1,  0,   0);
        step(0, "wimwe_save",    0,  0,  0,  0, 1, 0, 0, 0,  1, 'h40,  6,   'h40, 0,   0,   -1,  0,   0);
        step(0, "cwpwe_7b",      0,  0,  0,  0, 0, 0, 1, 7,  0, 0,     7,   'h40, 0,   0,   -1,  0,   0);
        step(0, "ovf_new_wim",   0,  0,  0,  0, 1, 0, 0, 0,  0, 0,     7,   'h40, 1,   0,   -1,  0,   0);

        step(1, "n5_save",       0,  0, 24, 16, 1, 0, 0, 0,  0, 0,     4,   0,    0,   0,   -1,  8,   80);
        step(1, "n5_restore",    0,  0, 24,  0, 0, 1, 0, 0,  0, 0,     0,   0,    0,   0,   -1,  24,  0);
        step(1, "n5_cwp_mod",    0,  0, 24,  0, 0, 0, 1, 6,  0, 0,     1,   0,    0,   0,   -1,  40,  0);
        step(1, "n5_wr_r31",     1, 31,  0,  0, 0, 0, 0, 0,  0, 0,     1,   0,    0,   0,   47,  0,   0);
        step(1, "n5_wim_01",     0,  0,  0,  0, 0, 0, 0, 0,  1, 1,     1,   1,    0,   0,   -1,  0,   0);
        step(1, "n5_ovf",        0,  0,  0,  0, 1, 0, 0, 0,  0, 0,     1,   1,    1,   0,   -1,  0,   0);

        // Reset asserted while a trap pulse and a write enable are live
        step(0, "pre_rst",       1,  1,  0,  0, 1, 0, 0, 0,  0, 0,     7,   'h40, 1,   0,   1,   0,   0);
        @(posedge clk); #2;
        push(0, "mid_rst",   0, 0, 0, 0, -1, 0, 0);
        push(1, "mid_rst5",  0, 0, 0, 0, -1, 0, 0);
        rst_n = 1'b0;
        #1;
        idle_all();
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        step(0, "post_rst",      0,  0,  0,  0, 0, 0, 0, 0,  0, 0,     0,   0,    0,   0,   -1,  0,   0);
        step(1, "post_rst5",     0,  0,  0,  0, 0, 0, 0, 0,  0, 0,     0,   0,    0,   0,   -1,  0,   0);

        @(posedge clk); #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
